// File: rtl/tdm_demultiplexer_if.sv
// Serial TDM link and per-channel parallel outputs of tdm_demultiplexer.
// master = link/consumer side, slave = the demultiplexer itself.
interface tdm_demultiplexer_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 8
);
    logic                         en;
    logic                         din;
    logic                         fs;
    logic [CHANNELS*WIDTH-1:0]    ch_data;
    logic [CHANNELS-1:0]          ch_valid;
    logic                         frame_done;
    logic                         sync_err;
    logic                         parity_err;

    modport master (
        output en, din, fs,
        input  ch_data, ch_valid, frame_done, sync_err, parity_err
    );

    modport slave (
        input  en, din, fs,
        output ch_data, ch_valid, frame_done, sync_err, parity_err
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// Serial TDM demultiplexer: splits fs-framed serial bits into CHANNELS registered words.
// Optional per-slot even parity bit enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demultiplexer #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tdm_demultiplexer_if.slave   bus
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SLOT_BITS = WIDTH + 1;
`else
    localparam int unsigned SLOT_BITS = WIDTH;
`endif
    localparam int unsigned SHW       = SLOT_BITS - 1;
    localparam int unsigned BCW       = $clog2(WIDTH + 1);
    localparam int unsigned SCW       = $clog2(CHANNELS);
    localparam int unsigned DW        = CHANNELS * WIDTH;

    localparam logic [BCW-1:0] LAST_BIT  = BCW'(SLOT_BITS - 1);
    localparam logic [SCW-1:0] LAST_SLOT = SCW'(CHANNELS - 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

    state_e               state_q,      state_d;
    logic [BCW-1:0]       bit_cnt_q,    bit_cnt_d;
    logic [SCW-1:0]       slot_cnt_q,   slot_cnt_d;
    logic [SHW-1:0]       shift_q,      shift_d;
    logic [DW-1:0]        ch_data_q,    ch_data_d;
    logic [CHANNELS-1:0]  ch_valid_q,   ch_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sync_err_q,   sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic                 parity_err_q, parity_err_d;
`endif

    // Bits already held plus the incoming bit form a complete slot on its last bit.
    logic [SLOT_BITS-1:0] word_c;
    logic                 frame_start_c;

    assign word_c        = {shift_q, bus.din};
    assign frame_start_c = (bit_cnt_q == '0) && (slot_cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        shift_d      = shift_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif

        if (bus.en) begin
            case (state_q)
                HUNT: begin
                    if (bus.fs) begin
                        state_d    = LOCKED;
                        shift_d    = SHW'(bus.din);
                        bit_cnt_d  = BCW'(1);
                        slot_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    if (frame_start_c && !bus.fs) begin
                        // Missing frame sync: drop lock and the bit.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        shift_d    = '0;
                        bit_cnt_d  = '0;
                        slot_cnt_d = '0;
                    end else if (!frame_start_c && bus.fs) begin
                        // Early frame sync: restart the frame on this bit.
                        sync_err_d = 1'b1;
                        shift_d    = SHW'(bus.din);
                        bit_cnt_d  = BCW'(1);
                        slot_cnt_d = '0;
                    end else begin
                        shift_d = word_c[SLOT_BITS-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            ch_data_d[int'(slot_cnt_q)*WIDTH +: WIDTH] = word_c[SLOT_BITS-1 -: WIDTH];
                            ch_valid_d[slot_cnt_q] = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                            parity_err_d = ^word_c;
`endif
                            bit_cnt_d = '0;
                            if (slot_cnt_q == LAST_SLOT) begin
                                frame_done_d = 1'b1;
                                slot_cnt_d   = '0;
                            end else begin
                                slot_cnt_d = slot_cnt_q + SCW'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            shift_q      <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            shift_q      <= shift_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.ch_data    = ch_data_q;
    assign bus.ch_valid   = ch_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Self-checking bench for tdm_demultiplexer against a bit-queue frame model.
// Honours TDM_DEMUX_PARITY_EN when defined for both bench and design.
module tb_tdm_demultiplexer;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SB = W + 1;
`else
    localparam int unsigned SB = W;
`endif
    localparam int unsigned FB = CH * SB;
    localparam int unsigned OW = CH * W + CH + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demultiplexer_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
    tdm_demultiplexer #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: lock flag plus the bits received so far in the current frame.
    bit              m_locked;
    bit              m_bits[$];
    logic [CH*W-1:0] m_data;
    logic [CH-1:0]   e_valid;
    logic            e_done, e_serr, e_perr;
    logic            dtog;

    function automatic void clear_pulses();
        e_valid = '0;
        e_done  = 1'b0;
        e_serr  = 1'b0;
        e_perr  = 1'b0;
    endfunction

    function automatic void model_reset();
        m_locked = 1'b0;
        m_bits.delete();
        m_data = '0;
        clear_pulses();
    endfunction

    function automatic void model_bit(input bit d, input bit f);
        int          slot;
        int          ones;
        logic [W-1:0] word;
        clear_pulses();
        if (!m_locked) begin
            if (f) begin
                m_locked = 1'b1;
                m_bits.push_back(d);
            end
            return;
        end
        if (m_bits.size() == 0 && !f) begin
            e_serr   = 1'b1;
            m_locked = 1'b0;
            return;
        end
        if (m_bits.size() != 0 && f) begin
            e_serr = 1'b1;
            m_bits.delete();
            m_bits.push_back(d);
            return;
        end
        m_bits.push_back(d);
        if (m_bits.size() % SB == 0) begin
            slot = m_bits.size() / SB - 1;
            ones = 0;
            word = '0;
            for (int i = 0; i < SB; i++) begin
                ones += int'(m_bits[slot*SB + i]);
                if (i < W) word = {word[W-2:0], m_bits[slot*SB + i]};
            end
            m_data[slot*W +: W] = word;
            e_valid[slot]       = 1'b1;
            e_perr              = (SB != W) && ones[0];
            if (slot == CH - 1) begin
                e_done = 1'b1;
                m_bits.delete();
            end
        end
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.ch_data, bus.ch_valid, bus.frame_done, bus.sync_err, bus.parity_err};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {m_data, e_valid, e_done, e_serr, e_perr};
    endfunction

    function automatic logic [FB-1:0] mk_frame(input logic [W-1:0] w0, input logic [W-1:0] w1);
`ifdef TDM_DEMUX_PARITY_EN
        return {w0, ^w0, w1, ^w1};
`else
        return {w0, w1};
`endif
    endfunction

    // One clock of stimulus; outputs are then sampled 1 ns after the edge.
    task automatic step(input logic e, input logic d, input logic f);
        bus.en  = e;
        bus.din = d;
        bus.fs  = f;
        @(posedge clk);
        #1;
        if (e) model_bit(d, f);
        else   clear_pulses();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.din = 1'b0; bus.fs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h expected 0", obs());
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            checks++;
            if (obs() !== '0) begin
                failures++;
                $display("FAIL hunt_no_fs bit %0d: got %h expected 0", i, obs());
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [FB-1:0] f;
        f = mk_frame(8'hA5, 8'h3C);
        for (int i = 0; i < FB; i++) begin
            step(1'b1, f[FB-1-i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL basic bit %0d: got %h expected %h", i, obs(), expv());
            end
            if (i == SB - 1) begin
                checks++;
                if (bus.ch_valid !== 2'b01 || bus.ch_data[7:0] !== 8'hA5) begin
                    failures++;
                    $display("FAIL basic_slot0: got valid=%b data=%h expected valid=01 data=a5", bus.ch_valid, bus.ch_data[7:0]);
                end
            end
            if (i == FB - 1) begin
                checks++;
                if (bus.ch_valid !== 2'b10 || bus.frame_done !== 1'b1 || bus.ch_data[15:8] !== 8'h3C) begin
                    failures++;
                    $display("FAIL basic_slot1: got valid=%b done=%b data=%h expected valid=10 done=1 data=3c",
                             bus.ch_valid, bus.frame_done, bus.ch_data[15:8]);
                end
            end
            dtog = ~dtog;
            step(1'b0, dtog, 1'($urandom));
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL basic_gap %0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_sync_loss();
        logic [FB-1:0] f;
        step(1'b1, 1'($urandom), 1'b0);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.ch_valid !== '0 || obs() !== expv()) begin
            failures++;
            $display("FAIL sync_loss: got %h expected %h", obs(), expv());
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL sync_loss_hunt %0d: got %h expected %h", i, obs(), expv());
            end
        end
        f = mk_frame(8'h11, 8'h22);
        for (int i = 0; i < FB; i++) begin
            step(1'b1, f[FB-1-i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL relock bit %0d: got %h expected %h", i, obs(), expv());
            end
            repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom));
        end
        checks++;
        if (bus.ch_data !== 16'h2211) begin
            failures++;
            $display("FAIL relock_data: got %h expected 2211", bus.ch_data);
        end
    endtask

    task automatic test_midframe_fs();
        logic [FB-1:0] f;
        f = mk_frame(8'hAA, 8'h55);
        for (int i = 0; i < SB + 5; i++) begin
            step(1'b1, f[FB-1-i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL partial bit %0d: got %h expected %h", i, obs(), expv());
            end
        end
        f = mk_frame(8'h0F, 8'hF0);
        for (int i = 0; i < FB; i++) begin
            step(1'b1, f[FB-1-i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL early_fs bit %0d: got %h expected %h", i, obs(), expv());
            end
            if (i == 0) begin
                checks++;
                if (bus.sync_err !== 1'b1 || bus.ch_valid !== '0 || bus.ch_data !== 16'h22AA) begin
                    failures++;
                    $display("FAIL early_fs_flag: got serr=%b valid=%b data=%h expected serr=1 valid=00 data=22aa",
                             bus.sync_err, bus.ch_valid, bus.ch_data);
                end
            end
        end
        checks++;
        if (bus.ch_data !== 16'hF00F) begin
            failures++;
            $display("FAIL early_fs_data: got %h expected f00f", bus.ch_data);
        end
    endtask

    task automatic test_reset_midframe();
        logic [FB-1:0] f;
        f = mk_frame(8'h77, 8'h88);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, f[FB-1-i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL pre_reset bit %0d: got %h expected %h", i, obs(), expv());
            end
        end
        bus.en = 1'b1; bus.din = f[FB-4]; bus.fs = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.en = 1'b0;
        model_reset();
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL midframe_reset: got %h expected 0", obs());
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            checks++;
            if (obs() !== '0) begin
                failures++;
                $display("FAIL post_reset_hunt %0d: got %h expected 0", i, obs());
            end
        end
        f = mk_frame(8'h12, 8'h34);
        for (int i = 0; i < FB; i++) begin
            step(1'b1, f[FB-1-i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL post_reset bit %0d: got %h expected %h", i, obs(), expv());
            end
        end
        checks++;
        if (bus.ch_data !== 16'h3412) begin
            failures++;
            $display("FAIL post_reset_data: got %h expected 3412", bus.ch_data);
        end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        logic [FB-1:0] f;
        f = {8'hA5, 1'b0, 8'h3C, 1'b1};
        for (int i = 0; i < FB; i++) begin
            step(1'b1, f[FB-1-i], i == 0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL parity bit %0d: got %h expected %h", i, obs(), expv());
            end
            if (i == SB - 1) begin
                checks++;
                if (bus.ch_valid !== 2'b01 || bus.parity_err !== 1'b0) begin
                    failures++;
                    $display("FAIL parity_slot0: got valid=%b perr=%b expected valid=01 perr=0", bus.ch_valid, bus.parity_err);
                end
            end
            if (i == FB - 1) begin
                checks++;
                if (bus.ch_valid !== 2'b10 || bus.parity_err !== 1'b1 || bus.ch_data[15:8] !== 8'h3C) begin
                    failures++;
                    $display("FAIL parity_slot1: got valid=%b perr=%b data=%h expected valid=10 perr=1 data=3c",
                             bus.ch_valid, bus.parity_err, bus.ch_data[15:8]);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [FB-1:0] f;
        logic          fsv;
        for (int n = 0; n < 30; n++) begin
            f = mk_frame(8'($urandom), 8'($urandom));
            if (SB != W && $urandom_range(0, 3) == 0) f[0] = ~f[0];
            for (int i = 0; i < FB; i++) begin
                fsv = (i == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
                step(1'b1, f[FB-1-i], fsv);
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL random frame %0d bit %0d: got %h expected %h", n, i, obs(), expv());
                end
                repeat ($urandom_range(0, 3)) begin
                    step(1'b0, 1'($urandom), 1'($urandom));
                    checks++;
                    if (obs() !== expv()) begin
                        failures++;
                        $display("FAIL random_gap frame %0d bit %0d: got %h expected %h", n, i, obs(), expv());
                    end
                end
            end
        end
    endtask

    initial begin
        dtog = 1'b0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_sync_loss();
        test_midframe_fs();
        test_reset_midframe();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
Serial time-division demultiplexer: the receive-side counterpart of the channel multiplexer.
- Takes one serial bit line framed by a frame-sync strobe.
- Splits each frame into CHANNELS slots of WIDTH bits.
- Presents each slot as a registered parallel word with a one-cycle valid pulse.
- Sits between the serial link input and the per-channel consumers.

Parameters:
CHANNELS, 2, number of time slots (channels) per frame; ≥2.
WIDTH, 8, data bits per slot; ≥2.

Ports:
clk  input  1  single system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  bit strobe; din and fs are sampled only in cycles with en=1.
din  input  1  serial data, MSB of each slot first.
fs  input  1  frame sync; fs=1 with en=1 marks din as bit 0 (MSB) of slot 0.
ch_data  output  CHANNELS*WIDTH  channel k word at ch_data[k*WIDTH +: WIDTH].
ch_valid  output  CHANNELS  one-hot one-cycle pulse; bit k means ch_data slice k was just updated.
frame_done  output  1  one-cycle pulse when the last slot of a frame is delivered.
sync_err  output  1  one-cycle pulse on a framing violation.
parity_err  output  1  one-cycle pulse on a slot parity failure (see Optional Feature).

Behaviour:
Reset and idle
- One clock domain (clk). Reset is synchronous and active-high (rst).
- On rst: all outputs 0, state HUNT, counters and shift register cleared.
- Reset mid-frame discards the partial slot and frame.
- Cycles with en=0: no state change, except that the output pulses clear.

States
- HUNT: ignore din until en=1 and fs=1.
  - That bit is shifted in as slot 0 bit 0; go to LOCKED with bit_cnt=1, slot_cnt=0.
- LOCKED: each en=1 shifts din into the LSB of the shift register and increments bit_cnt.
  - When the last bit of a slot is shifted (bit_cnt = SLOT_BITS-1), the next clock edge:
    - writes the WIDTH data bits into ch_data slice slot_cnt;
    - pulses ch_valid[slot_cnt];
    - resets bit_cnt to 0 and increments slot_cnt.
  - On the last slot (slot_cnt = CHANNELS-1), frame_done pulses in the same cycle as ch_valid, and slot_cnt wraps to 0.
- SLOT_BITS = WIDTH normally; WIDTH+1 with the optional feature.

Latency and retention
- Latency is exactly one clock from the en cycle carrying a slot's last bit to its ch_valid.
- ch_data slices hold their value until overwritten by the same channel or by reset.

Framing checks (evaluated in LOCKED, en=1 only)
- Frame position 0 with fs=0: pulse sync_err, go HUNT, discard the bit.
- Nonzero frame position with fs=1: pulse sync_err, discard the partial frame, treat the bit as slot 0 bit 0, stay LOCKED.
- No ch_valid is issued for any discarded slot.
- sync_err and ch_valid never pulse in the same cycle.

Counter widths
- bit_cnt is $clog2(WIDTH+1) bits; slot_cnt is $clog2(CHANNELS) bits.
- Both wrap exactly at their terminal values, never by natural overflow.

Optional Feature:
Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - Each slot carries WIDTH data bits followed by one even-parity bit (XOR of all WIDTH+1 bits = 0).
  - On slot delivery, ch_data and ch_valid update as usual.
  - parity_err pulses in the same cycle if the parity check fails.
  - Framing is otherwise unchanged.
- Undefined:
  - Slots are WIDTH bits.
  - parity_err is tied to 0.

Test Plan:
1. rst=1 for 2 cycles, then 20 en pulses with fs=0 and random din.
   - Required: all outputs remain 0; no ch_valid.
2. Frame with fs on bit 0, din = 0xA5 then 0x3C, en high every other cycle, din toggling while en=0.
   - Required: ch_valid=2'b01 one clock after the 8th en, with ch_data[7:0]=0xA5.
   - Required: ch_valid=2'b10 with frame_done=1 one clock after the 16th en, with ch_data[15:8]=0x3C.
3. After a good frame, the next en bit has fs=0.
   - Required: sync_err pulses one cycle; no ch_valid until the next fs.
   - Required: the next frame 0x11/0x22 decodes correctly.
4. fs asserted on bit 5 of slot 1.
   - Required: sync_err pulses; no ch_valid[1]; ch_data retains the prior values.
   - Required: the following 16 bits 0x0F/0xF0 decode as a new frame.
5. rst asserted at slot 0 bit 3 of frame 0x77/0x88.
   - Required: ch_data=0 and state HUNT.
   - Required: a subsequent fs-framed 0x12/0x34 decodes correctly.
6. With TDM_DEMUX_PARITY_EN, send 0xA5+parity 0 and then 0x3C+parity 1.
   - Required: slot 0 delivered with parity_err=0.
   - Required: slot 1 delivered with ch_data=0x3C and parity_err=1 in the ch_valid[1] cycle.
